// File: rtl/layer_transfer_ctrl_pkg.sv
// Shared types and constants for the layer-to-layer transfer sequencer.
package layer_transfer_ctrl_pkg;

    // Address width of the layer BRAM ports.
    localparam int unsigned ADDR_W = 10;

    // Deepest source read latency the delay line is built for.
    localparam int unsigned MAX_RD_LAT = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/xfer_delay_line.sv
// Depth-stage shift register carrying {valid, addr1, addr2} from the source read
// side to the destination write side, so each write lands Depth cycles after its read.
module xfer_delay_line #(
    parameter int unsigned Depth = 2,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [AddrW-1:0] in_addr1_i,
    input  logic [AddrW-1:0] in_addr2_i,
    output logic             out_valid_o,
    output logic [AddrW-1:0] out_addr1_o,
    output logic [AddrW-1:0] out_addr2_o,
    output logic             upstream_valid_o
);

    logic [Depth-1:0] valid_q;
    logic [AddrW-1:0] addr1_q [Depth];
    logic [AddrW-1:0] addr2_q [Depth];

    // Shift every cycle; synchronous active-low clear empties the whole line.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                addr1_q[i] <= '0;
                addr2_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            addr1_q[0] <= in_addr1_i;
            addr2_q[0] <= in_addr2_i;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr1_q[i] <= addr1_q[i-1];
                addr2_q[i] <= addr2_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[Depth-1];
    assign out_addr1_o = addr1_q[Depth-1];
    assign out_addr2_o = addr2_q[Depth-1];

    // Any valid still short of the final stage means more writes are coming.
    if (Depth > 1) begin : gen_upstream
        assign upstream_valid_o = |valid_q[Depth-2:0];
    end else begin : gen_no_upstream
        assign upstream_valid_o = 1'b0;
    end

endmodule

// File: rtl/layer_transfer_ctrl.sv
// Copies a finished layer's feature map into the next layer's input and skip memories:
// issues source read address pairs, then replays them as destination writes after RD_LAT.
module layer_transfer_ctrl
    import layer_transfer_ctrl_pkg::*;
#(
    parameter int unsigned N_WORDS = 400,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              WRITE,
    output logic [ADDR_W-1:0] TRANS_ADDR1,
    output logic [ADDR_W-1:0] TRANS_ADDR2,
    output logic              REG_WRITE,
    output logic [ADDR_W-1:0] REG_TRANS_ADDR1,
    output logic [ADDR_W-1:0] REG_TRANS_ADDR2,
    output logic              busy,
    output logic              done
);

    if (N_WORDS < 2 || (N_WORDS % 2) != 0 || N_WORDS > 1024) begin : gen_bad_n_words
        $error("N_WORDS must be even and in 2..1024");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : gen_bad_rd_lat
        $error("RD_LAT must be in 1..MAX_RD_LAT");
    end

    // Index of the final pair; terminal detection never relies on counter overflow.
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_WORDS / 2 - 1);

    xfer_state_e       state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] last_addr1_q;
    logic [ADDR_W-1:0] last_addr2_q;
    logic              issue;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              upstream_valid;

    // Read issue and source-side address mux; hold parks the last issued pair.
    always_comb begin
        issue       = (state_q == READ) && !hold;
        rd_addr1    = cnt_q << 1;
        rd_addr2    = rd_addr1 | ADDR_W'(1);
        WRITE       = issue;
        TRANS_ADDR1 = issue ? rd_addr1 : last_addr1_q;
        TRANS_ADDR2 = issue ? rd_addr2 : last_addr2_q;
        busy        = (state_q != IDLE);
        done        = (state_q == FIN);
    end

    // Sequencer FSM and pair counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_addr1_q <= '0;
            last_addr2_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= READ;
                        cnt_q   <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        last_addr1_q <= rd_addr1;
                        last_addr2_q <= rd_addr2;
                        if (cnt_q == LAST_K) begin
                            state_q <= DRAIN;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                // Leave once only the final stage can still hold a write, so done
                // lands the cycle after the last REG_WRITE.
                DRAIN: begin
                    if (!upstream_valid) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    xfer_delay_line #(
        .Depth(RD_LAT),
        .AddrW(ADDR_W)
    ) u_delay (
        .clk_i           (clk),
        .rst_ni          (rst),
        .in_valid_i      (issue),
        .in_addr1_i      (TRANS_ADDR1),
        .in_addr2_i      (TRANS_ADDR2),
        .out_valid_o     (REG_WRITE),
        .out_addr1_o     (REG_TRANS_ADDR1),
        .out_addr2_o     (REG_TRANS_ADDR2),
        .upstream_valid_o(upstream_valid)
    );

endmodule

// File: tb/tb_layer_transfer_ctrl.sv
// Bench for layer_transfer_ctrl: two configurations driven by shared directed and
// random stimulus, each compared cycle by cycle against a timing-rule reference model.
module tb_layer_transfer_ctrl;
    import layer_transfer_ctrl_pkg::*;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b0;
    logic start = 1'b0;
    logic hold  = 1'b0;

    logic              a_write, a_reg_write, a_busy, a_done;
    logic [ADDR_W-1:0] a_ta1, a_ta2, a_ra1, a_ra2;
    logic              b_write, b_reg_write, b_busy, b_done;
    logic [ADDR_W-1:0] b_ta1, b_ta2, b_ra1, b_ra2;

    layer_transfer_ctrl #(.N_WORDS(8), .RD_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .WRITE(a_write), .TRANS_ADDR1(a_ta1), .TRANS_ADDR2(a_ta2),
        .REG_WRITE(a_reg_write), .REG_TRANS_ADDR1(a_ra1), .REG_TRANS_ADDR2(a_ra2),
        .busy(a_busy), .done(a_done)
    );

    layer_transfer_ctrl #(.N_WORDS(2), .RD_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .WRITE(b_write), .TRANS_ADDR1(b_ta1), .TRANS_ADDR2(b_ta2),
        .REG_WRITE(b_reg_write), .REG_TRANS_ADDR1(b_ra1), .REG_TRANS_ADDR2(b_ra2),
        .busy(b_busy), .done(b_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: per-instance transfer bookkeeping plus a log of issue cycles.
    int                nw       [2] = '{8, 2};
    int                rl       [2] = '{2, 1};
    bit                active   [2];
    int                k        [2];
    int                done_at  [2];
    int                rst_last [2];
    bit                exp_w    [2];
    logic [ADDR_W-1:0] la1      [2];
    logic [ADDR_W-1:0] la2      [2];
    bit                iss      [2][MAXC];
    logic [ADDR_W-1:0] ia1      [2][MAXC];
    logic [ADDR_W-1:0] ia2      [2][MAXC];

    task automatic check_eq(input string tag, input int m, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h", tag, m, cyc, got, exp);
        end
    endtask

    task automatic check_all(input int m);
        logic              g_w, g_rw, g_busy, g_done;
        logic [ADDR_W-1:0] g_a1, g_a2, g_r1, g_r2;
        logic [ADDR_W-1:0] e_a1, e_a2;
        bit                e_rw;
        int                src;
        if (m == 0) begin
            g_w = a_write; g_a1 = a_ta1; g_a2 = a_ta2; g_rw = a_reg_write;
            g_r1 = a_ra1; g_r2 = a_ra2; g_busy = a_busy; g_done = a_done;
        end else begin
            g_w = b_write; g_a1 = b_ta1; g_a2 = b_ta2; g_rw = b_reg_write;
            g_r1 = b_ra1; g_r2 = b_ra2; g_busy = b_busy; g_done = b_done;
        end
        exp_w[m] = active[m] && (k[m] < nw[m] / 2) && !hold;
        e_a1 = exp_w[m] ? ADDR_W'(2 * k[m])     : la1[m];
        e_a2 = exp_w[m] ? ADDR_W'(2 * k[m] + 1) : la2[m];
        src  = cyc - rl[m];
        e_rw = 1'b0;
        if (src > rst_last[m]) e_rw = iss[m][src];
        check_eq("write", m, 32'(g_w), 32'(exp_w[m]));
        check_eq("trans_addr1", m, 32'(g_a1), 32'(e_a1));
        check_eq("trans_addr2", m, 32'(g_a2), 32'(e_a2));
        check_eq("reg_write", m, 32'(g_rw), 32'(e_rw));
        if (e_rw) begin
            check_eq("reg_addr1", m, 32'(g_r1), 32'(ia1[m][src]));
            check_eq("reg_addr2", m, 32'(g_r2), 32'(ia2[m][src]));
        end
        check_eq("busy", m, 32'(g_busy), 32'(active[m]));
        check_eq("done", m, 32'(g_done), 32'(cyc == done_at[m]));
    endtask

    // Advance the model across the clock edge that ends cycle 'cyc'.
    task automatic update(input int m);
        if (!rst) begin
            active[m]   = 1'b0;
            k[m]        = 0;
            done_at[m]  = -1;
            la1[m]      = '0;
            la2[m]      = '0;
            rst_last[m] = cyc;
        end else if (active[m]) begin
            if (exp_w[m]) begin
                iss[m][cyc] = 1'b1;
                ia1[m][cyc] = ADDR_W'(2 * k[m]);
                ia2[m][cyc] = ADDR_W'(2 * k[m] + 1);
                la1[m]      = ia1[m][cyc];
                la2[m]      = ia2[m][cyc];
                k[m]++;
                if (k[m] == nw[m] / 2) done_at[m] = cyc + rl[m] + 1;
            end
            if (cyc == done_at[m]) active[m] = 1'b0;
        end else if (start) begin
            active[m]  = 1'b1;
            k[m]       = 0;
            done_at[m] = -1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic h);
        @(negedge clk);
        rst   = r;
        start = s;
        hold  = h;
        #1;
        for (int m = 0; m < 2; m++) begin
            if (cyc > 0) check_all(m);
            else exp_w[m] = 1'b0;
            update(m);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            active[m]   = 1'b0;
            k[m]        = 0;
            done_at[m]  = -1;
            rst_last[m] = -1;
            la1[m]      = '0;
            la2[m]      = '0;
        end

        // Reset held, start while still in reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(2);

        // Plain transfer.
        step(1'b1, 1'b1, 1'b0);
        idle(10);

        // Hold during cycles 2-3.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(10);

        // Start pulses while busy.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        idle(8);

        // Reset mid-transfer, then a fresh start.
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0);
        idle(6);
        step(1'b1, 1'b1, 1'b0);
        idle(10);

        // Start and hold together; hold across the final pair.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(8);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0));
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_transfer_ctrl.md
Name: layer_transfer_ctrl

Overview:
- Sequencer that copies one finished layer's output feature map into the next layer's input memory and skip memory.
- It drives the source layer's read side: WRITE and TRANS_ADDR1/2 into that layer's BRAM2.
- It drives the destination layer's write side: REG_WRITE and REG_TRANS_ADDR1/2 into memory1 and memory_skip.
- Data is wired externally from source BRAM2_out to destination INPUT_LAYER; this block generates only addresses and strobes and accounts for the fixed BRAM read latency.

Parameters:
- N_WORDS, 400: words per BRAM bank to transfer. Must be even and ≤ 1024.
- RD_LAT, 2: source BRAM read latency in clk cycles, from address to data valid at INPUT_LAYER. Legal range 1..4.
- ADDR_W, 10: address width, matching the layer BRAM address ports.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a transfer. Ignored unless in IDLE.
- hold  in  1  when high, stops issuing new read addresses; in-flight reads still drain.
- WRITE  out  1  to source layer: read phase active; source addresses muxed to TRANS_ADDR.
- TRANS_ADDR1  out  ADDR_W  source read address, port 1.
- TRANS_ADDR2  out  ADDR_W  source read address, port 2.
- REG_WRITE  out  1  to destination layer: write strobe for memory1 and memory_skip.
- REG_TRANS_ADDR1  out  ADDR_W  destination write address, port 1.
- REG_TRANS_ADDR2  out  ADDR_W  destination write address, port 2.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last destination write has completed.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, all addresses to 0.
  - The RD_LAT-deep valid/address pipeline is cleared.
  - Reset mid-transfer aborts immediately: no further REG_WRITE and no done pulse.
- FSM states:
  - IDLE -> READ on start.
  - READ -> DRAIN after the last read pair is issued.
  - DRAIN -> FIN when the pipeline is empty.
  - FIN -> IDLE unconditionally; done=1 during FIN.
- Read issue:
  - Each READ cycle with hold=0 issues one pair: WRITE=1, TRANS_ADDR1=2k, TRANS_ADDR2=2k+1, for k = 0 .. N_WORDS/2-1.
  - Any cycle with hold=1 in READ: WRITE=0, the counter is frozen, and the addresses hold their last value.
- Pipeline:
  - An issue flag plus the two addresses enter an RD_LAT-stage shift register.
  - The register shifts every cycle, regardless of hold.
  - REG_WRITE is the valid output of the final stage.
  - REG_TRANS_ADDR1/2 are the delayed TRANS_ADDR1/2, so each write lands exactly RD_LAT cycles after its read.
- Latency:
  - start accepted at edge 0 -> first WRITE at cycle 1 -> first REG_WRITE at cycle 1+RD_LAT.
  - With no hold, the last REG_WRITE is at cycle N_WORDS/2+RD_LAT and done at the following cycle.
- busy is 1 in READ, DRAIN and FIN.
- start while busy is ignored, with no queueing.
- start and hold asserted in the same cycle: the start is accepted, but the first issue waits until hold falls.
- Address counter:
  - Width ADDR_W, with no wrap-around within a transfer.
  - Terminal detection is by comparison to N_WORDS/2-1, never by overflow.
- hold asserted in the cycle the last pair would issue: the FSM stays in READ until that pair is issued.
- REG_WRITE never asserts in IDLE, and never for a cycle where WRITE was 0 RD_LAT cycles earlier.

Decomposition:
- Shared package holds:
  - ADDR_W;
  - the state encoding localparams (IDLE=2'd0, READ=2'd1, DRAIN=2'd2, FIN=2'd3);
  - a MAX_RD_LAT constant of 4 for range checking.
- One natural sub-module, xfer_delay_line: a parameterised RD_LAT-deep shift register carrying {valid, addr1, addr2}, with synchronous active-low clear.
- The top-level block holds the FSM and the address counter.

Test Plan:
1. rst=0 for 3 cycles, then start=1 while rst is still 0 -> all outputs stay 0 and busy stays 0.
2. N_WORDS=8, RD_LAT=2, single start:
   - WRITE high for cycles 1-4 with TRANS_ADDR1/2 = (0,1), (2,3), (4,5), (6,7).
   - REG_WRITE high for cycles 3-6 with the same address pairs.
   - done pulses at cycle 7; busy high for cycles 1-7.
3. Same configuration, hold=1 during cycles 2-3 -> pairs issue at cycles 1, 4, 5, 6.
   - REG_WRITE at cycles 3, 6, 7, 8 with the correct addresses.
   - No REG_WRITE in cycles 4-5; done at cycle 9.
4. start pulses at cycles 2 and 5 while busy -> ignored; exactly 4 writes, then one done.
5. rst=0 at cycle 3 of a transfer -> the next cycle shows WRITE=0, REG_WRITE=0, busy=0; no done ever follows.
   - A fresh start afterwards restarts from address 0.
6. RD_LAT=1, N_WORDS=2 -> WRITE at cycle 1 (0,1), REG_WRITE at cycle 2 (0,1), done at cycle 3.
